// File: rtl/addsub_serial.sv
// rtl/addsub_serial.sv - digit-serial two's-complement adder/subtractor, DIGIT bits per clock
// Optional saturation on signed overflow: define ADDSUB_SAT_EN.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NDIG - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] idx;

  logic             accept;
  logic             last;
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] final_res;
  logic             msb_cin;
  logic             ovf_raw;

  assign accept = start && (state == IDLE);
  assign last   = (state == RUN) && (idx == LAST_IDX);
  assign busy   = (state == RUN);

  // Low digit of the shift registers is always the digit being processed.
  assign dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};

  // Completed digits enter at the top, so after NDIG shifts acc is the full sum.
  assign acc_nxt = (acc >> DIGIT)
                 | (WIDTH'(dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  // Carry into the top bit of the digit, recovered from its sum bit.
  assign msb_cin = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ dsum[DIGIT-1];
  assign ovf_raw = msb_cin ^ dsum[DIGIT];

`ifdef ADDSUB_SAT_EN
  logic             a_sign;
  logic [WIDTH-1:0] sat_val;

  // Overflow direction follows the sign of A (both operands share it on overflow).
  assign sat_val   = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign final_res = ovf_raw ? sat_val : acc_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sign <= 1'b0;
    end else if (accept) begin
      a_sign <= a[WIDTH-1];
    end
  end
`else
  assign final_res = acc_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh  <= a;
        b_sh  <= sub ? ~b : b;
        carry <= sub;
        idx   <= '0;
      end else if (state == RUN) begin
        a_sh  <= a_sh >> DIGIT;
        b_sh  <= b_sh >> DIGIT;
        acc   <= acc_nxt;
        carry <= dsum[DIGIT];
        idx   <= idx + 1'b1;
        if (last) begin
          result <= final_res;
          cout   <= dsum[DIGIT];
          ovf    <= ovf_raw;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_serial.sv
// tb/tb_addsub_serial.sv - directed self-checking bench for addsub_serial (WIDTH=16, DIGIT=4)
module tb_addsub_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_pass   = 0;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Counts edges after the accept edge until done; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic launch(input logic [15:0] va, input logic [15:0] vb, input logic vs);
    a = va; b = vb; sub = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                       input logic vs, input logic [15:0] er, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    launch(va, vb, vs);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'd4);
    check({tag, "_res"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int n_done;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outs", {13'd0, done, cout, ovf, result}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    do_op("add",   16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    check("hold_res", 32'(result), 32'h2224);
    do_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef ADDSUB_SAT_EN
    do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    do_op("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
    do_op("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    // start while busy must be ignored
    @(negedge clk);
    launch(16'h1234, 16'h0FF0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    launch(16'h0001, 16'h0001, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ign_done_c4", 32'(done), 32'd1);
    check("ign_res", 32'(result), 32'h2224);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("ign_no_extra", 32'(n_done), 32'd0);

    // start in the done cycle begins the next operation without a gap
    @(negedge clk);
    launch(16'h1000, 16'h0234, 1'b0);
    wait_done(lat);
    check("b2b_lat1", 32'(lat), 32'd4);
    launch(16'h1000, 16'h0001, 1'b1);
    check("b2b_busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("b2b_lat2", 32'(lat), 32'd4);
    check("b2b_res", 32'(result), 32'h0FFF);
    check("b2b_cout", 32'(cout), 32'd1);

    // reset mid-operation discards the operation
    @(negedge clk);
    launch(16'h0F0F, 16'h0101, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_outs", {13'd0, done, cout, ovf, result}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check("mid_rst_nodone", 32'(n_done), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("post_rst_quiet", 32'(n_done), 32'd0);
    do_op("post_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
